// File: rtl/shadow_ray_scheduler_if.sv
// Shared payload types and the request/generator/output bus of the
// shadow-ray scheduler.
//   shadow_ray_pkg          : fixed-point vector, light, AABB result and ray types
//   shadow_ray_scheduler_if : req_* (request in), gen_* (generator handshake),
//                             out_* (tagged shadow-ray records to occlusion)
//   modport master          : scheduler side
//   modport slave           : environment side (requester, generator, downstream)
package shadow_ray_pkg;
   localparam int unsigned FX_W = 24;

   typedef struct packed {
      logic [FX_W-1:0] x;
      logic [FX_W-1:0] y;
      logic [FX_W-1:0] z;
   } Vec3_t;

   typedef struct packed {
      Vec3_t           position;
      logic [FX_W-1:0] intensity;
   } LightSource_t;

   typedef struct packed {
      logic            hit;
      logic [FX_W-1:0] t_near;
      logic [FX_W-1:0] t_far;
   } AABB_result_t;

   typedef struct packed {
      Vec3_t           origin;
      Vec3_t           dir;
      logic [FX_W-1:0] t_max;
   } Ray;
endpackage

interface shadow_ray_scheduler_if #(
   parameter int unsigned TAG_W = 8,
   parameter int unsigned LI_W  = 2
);
   import shadow_ray_pkg::*;

   logic             req_valid;
   logic             req_ready;
   AABB_result_t     req_result;
   Vec3_t            req_hit_point;
   logic [TAG_W-1:0] req_tag;

   logic             gen_start;
   AABB_result_t     gen_test_result;
   LightSource_t     gen_light;
   Vec3_t            gen_hit_point;
   logic             gen_valid;
   Ray               gen_shadow_ray;

   logic             out_valid;
   logic             out_ready;
   Ray               out_ray;
   logic [TAG_W-1:0] out_tag;
   logic [LI_W-1:0]  out_light_idx;
   logic             out_skip;
   logic             out_last;

   modport master (
      input  req_valid, req_result, req_hit_point, req_tag,
      output req_ready,
      output gen_start, gen_test_result, gen_light, gen_hit_point,
      input  gen_valid, gen_shadow_ray,
      output out_valid, out_ray, out_tag, out_light_idx, out_skip, out_last,
      input  out_ready
   );

   modport slave (
      output req_valid, req_result, req_hit_point, req_tag,
      input  req_ready,
      input  gen_start, gen_test_result, gen_light, gen_hit_point,
      output gen_valid, gen_shadow_ray,
      input  out_valid, out_ray, out_tag, out_light_idx, out_skip, out_last,
      output out_ready
   );
endinterface

// File: rtl/shadow_ray_scheduler.sv
// Shadow-ray scheduler: accepts one AABB result per request, walks the enabled
// lights of an on-chip table in ascending order, issues one generator start per
// (hit, light) pair and emits one tagged record per light. Misses and hits with
// no enabled light produce a single skip record.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   cfg_we/idx/light   : light table write port
//   cfg_light_en       : per-light enable mask, snapshotted at accept
//   bus (master)       : req_*, gen_*, out_* channels
//   timeout_err        : sticky generator watchdog flag
// Optional feature: define SHADOW_SCHED_TIMEOUT_EN to build the WAIT watchdog;
// without it WAIT waits forever and timeout_err is tied low.
module shadow_ray_scheduler
   import shadow_ray_pkg::*;
#(
   parameter int unsigned WIDTH          = 24,
   parameter int unsigned Q_BITS         = 12,
   parameter int unsigned NUM_LIGHTS     = 4,
   parameter int unsigned TAG_W          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned LI_W          = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [LI_W-1:0]       cfg_idx,
   input  LightSource_t          cfg_light,
   input  logic [NUM_LIGHTS-1:0] cfg_light_en,
   shadow_ray_scheduler_if.master bus,
   output logic                  timeout_err
);

   // Payload types are fixed to the package word width; reject mismatched builds.
   if (WIDTH != FX_W || Q_BITS >= WIDTH || NUM_LIGHTS == 0 || NUM_LIGHTS > 16 ||
       TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("shadow_ray_scheduler: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t                state_q, state_d;
   LightSource_t          light_tbl_q [NUM_LIGHTS];
   logic [NUM_LIGHTS-1:0] mask_q, mask_d;
   logic [LI_W-1:0]       cur_idx_q, cur_idx_d;
   AABB_result_t          res_q, res_d;
   Vec3_t                 hit_point_q, hit_point_d;
   LightSource_t          gen_light_q, gen_light_d;
   logic                  gen_start_q, gen_start_d;
   logic                  req_ready_q, req_ready_d;
   logic                  out_valid_q, out_valid_d;
   Ray                    out_ray_q, out_ray_d;
   logic [TAG_W-1:0]      out_tag_q, out_tag_d;
   logic [LI_W-1:0]       out_light_idx_q, out_light_idx_d;
   logic                  out_skip_q, out_skip_d;
   logic                  out_last_q, out_last_d;

   logic                  cfg_wr_c;
   logic                  load_light_c;
   logic [LI_W-1:0]       first_idx_c;
   logic [LI_W-1:0]       next_idx_c;
   logic                  has_next_c;

`ifdef SHADOW_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;
`endif

   assign cfg_wr_c = cfg_we && (32'(cfg_idx) < 32'(NUM_LIGHTS));

   // Lowest enabled light at accept, and next enabled light above the current one.
   always_comb begin
      first_idx_c = '0;
      next_idx_c  = '0;
      has_next_c  = 1'b0;
      for (int unsigned i = NUM_LIGHTS; i > 0; i--) begin
         if (cfg_light_en[i-1]) first_idx_c = LI_W'(i-1);
         if (mask_q[i-1] && ((i - 1) > 32'(cur_idx_q))) begin
            next_idx_c = LI_W'(i-1);
            has_next_c = 1'b1;
         end
      end
   end

   // Light table; entries persist across requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_LIGHTS; i++) light_tbl_q[i] <= '0;
      end else if (cfg_wr_c) begin
         light_tbl_q[cfg_idx] <= cfg_light;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d         = state_q;
      mask_d          = mask_q;
      cur_idx_d       = cur_idx_q;
      res_d           = res_q;
      hit_point_d     = hit_point_q;
      gen_light_d     = gen_light_q;
      gen_start_d     = 1'b0;
      out_valid_d     = out_valid_q;
      out_ray_d       = out_ray_q;
      out_tag_d       = out_tag_q;
      out_light_idx_d = out_light_idx_q;
      out_skip_d      = out_skip_q;
      out_last_d      = out_last_q;
      load_light_c    = 1'b0;
`ifdef SHADOW_SCHED_TIMEOUT_EN
      wait_cnt_d      = '0;
      timeout_d       = timeout_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               res_d       = bus.req_result;
               hit_point_d = bus.req_hit_point;
               out_tag_d   = bus.req_tag;
               mask_d      = cfg_light_en;
               if (!bus.req_result.hit || cfg_light_en == '0) begin
                  out_valid_d     = 1'b1;
                  out_ray_d       = '0;
                  out_skip_d      = 1'b1;
                  out_light_idx_d = '0;
                  out_last_d      = 1'b1;
                  state_d         = EMIT;
               end else begin
                  cur_idx_d    = first_idx_c;
                  load_light_c = 1'b1;
                  gen_start_d  = 1'b1;
                  state_d      = ISSUE;
               end
            end
         end

         ISSUE: state_d = WAIT;

         WAIT: begin
            if (bus.gen_valid) begin
               out_valid_d     = 1'b1;
               out_ray_d       = bus.gen_shadow_ray;
               out_skip_d      = 1'b0;
               out_light_idx_d = cur_idx_q;
               out_last_d      = !has_next_c;
               state_d         = EMIT;
            end
`ifdef SHADOW_SCHED_TIMEOUT_EN
            else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               // Silent generator: report this light as skipped and move on.
               timeout_d       = 1'b1;
               out_valid_d     = 1'b1;
               out_ray_d       = '0;
               out_skip_d      = 1'b1;
               out_light_idx_d = cur_idx_q;
               out_last_d      = !has_next_c;
               state_d         = EMIT;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
`endif
         end

         EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  state_d = IDLE;
               end else begin
                  cur_idx_d    = next_idx_c;
                  load_light_c = 1'b1;
                  gen_start_d  = 1'b1;
                  state_d      = ISSUE;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Light is latched on entry to ISSUE so it is valid with gen_start;
      // a same-edge table write to that entry is forwarded.
      if (load_light_c) begin
         gen_light_d = (cfg_wr_c && cfg_idx == cur_idx_d) ? cfg_light
                                                         : light_tbl_q[cur_idx_d];
      end

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         mask_q          <= '0;
         cur_idx_q       <= '0;
         res_q           <= '0;
         hit_point_q     <= '0;
         gen_light_q     <= '0;
         gen_start_q     <= 1'b0;
         req_ready_q     <= 1'b1;
         out_valid_q     <= 1'b0;
         out_ray_q       <= '0;
         out_tag_q       <= '0;
         out_light_idx_q <= '0;
         out_skip_q      <= 1'b0;
         out_last_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         mask_q          <= mask_d;
         cur_idx_q       <= cur_idx_d;
         res_q           <= res_d;
         hit_point_q     <= hit_point_d;
         gen_light_q     <= gen_light_d;
         gen_start_q     <= gen_start_d;
         req_ready_q     <= req_ready_d;
         out_valid_q     <= out_valid_d;
         out_ray_q       <= out_ray_d;
         out_tag_q       <= out_tag_d;
         out_light_idx_q <= out_light_idx_d;
         out_skip_q      <= out_skip_d;
         out_last_q      <= out_last_d;
      end
   end

`ifdef SHADOW_SCHED_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign bus.req_ready       = req_ready_q;
   assign bus.gen_start       = gen_start_q;
   assign bus.gen_test_result = res_q;
   assign bus.gen_light       = gen_light_q;
   assign bus.gen_hit_point   = hit_point_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_ray         = out_ray_q;
   assign bus.out_tag         = out_tag_q;
   assign bus.out_light_idx   = out_light_idx_q;
   assign bus.out_skip        = out_skip_q;
   assign bus.out_last        = out_last_q;

endmodule

// File: tb/tb_shadow_ray_scheduler.sv
// Directed bench for shadow_ray_scheduler: miss, multi-light hit with
// backpressure, empty mask, same-edge table write, reset mid-WAIT and the
// silent-generator case (watchdog when SHADOW_SCHED_TIMEOUT_EN is defined).
module tb_shadow_ray_scheduler;
   import shadow_ray_pkg::*;

   localparam int unsigned TAG_W = 8;
   localparam int unsigned LI_W  = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_we;
   logic [1:0]   cfg_idx;
   LightSource_t cfg_light;
   logic [3:0]   cfg_light_en;
   logic         timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   shadow_ray_scheduler_if #(.TAG_W(TAG_W), .LI_W(LI_W)) bus ();

   shadow_ray_scheduler #(
      .WIDTH(24), .Q_BITS(12), .NUM_LIGHTS(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_light(cfg_light),
      .cfg_light_en(cfg_light_en),
      .bus(bus),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic LightSource_t mk_light(input int unsigned i);
      LightSource_t l;
      l.position.x = 24'(i * 16 + 1);
      l.position.y = 24'(i * 16 + 2);
      l.position.z = 24'(i * 16 + 3);
      l.intensity  = 24'(32'hA00 + i);
      return l;
   endfunction

   function automatic Ray mk_ray(input int unsigned s);
      Ray r;
      r.origin.x = 24'(s + 1);
      r.origin.y = 24'(s + 2);
      r.origin.z = 24'(s + 3);
      r.dir.x    = 24'(s + 4);
      r.dir.y    = 24'(s + 5);
      r.dir.z    = 24'(s + 6);
      r.t_max    = 24'(s + 7);
      return r;
   endfunction

   task automatic request(input logic hit, input logic [7:0] tag);
      bus.req_valid             = 1'b1;
      bus.req_result.hit        = hit;
      bus.req_result.t_near     = 24'h000100;
      bus.req_result.t_far      = 24'h000200;
      bus.req_hit_point.x       = 24'h001000 + 24'(tag);
      bus.req_hit_point.y       = 24'h002000;
      bus.req_hit_point.z       = 24'h003000;
      bus.req_tag               = tag;
   endtask

   initial begin
      Vec3_t        hp_exp;
      AABB_result_t res_exp;
      LightSource_t lnew;
      int           cnt;

      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_light = '0; cfg_light_en = '0;
      bus.req_valid = 1'b0; bus.req_result = '0; bus.req_hit_point = '0; bus.req_tag = '0;
      bus.gen_valid = 1'b0; bus.gen_shadow_ray = '0; bus.out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_req_ready", 256'(bus.req_ready), 256'(1));
      check("rst_gen_start", 256'(bus.gen_start), 256'(0));
      check("rst_out_valid", 256'(bus.out_valid), 256'(0));
      check("rst_out_skip",  256'(bus.out_skip),  256'(0));
      check("rst_out_last",  256'(bus.out_last),  256'(0));
      check("rst_out_ray",   256'(bus.out_ray),   256'(0));
      check("rst_out_tag",   256'(bus.out_tag),   256'(0));
      check("rst_gen_light", 256'(bus.gen_light), 256'(0));
      check("rst_timeout",   256'(timeout_err),   256'(0));

      // Load light table
      for (int i = 0; i < 4; i++) begin
         cfg_we = 1'b1; cfg_idx = 2'(i); cfg_light = mk_light(i);
         tick();
      end
      cfg_we = 1'b0;

      // gen_valid in IDLE is ignored
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(9);
      tick();
      bus.gen_valid = 1'b0;
      check("idle_gen_valid_ignored", 256'(bus.out_valid), 256'(0));

      // Miss, tag 0x11: skip record at T+1
      cfg_light_en = 4'hF;
      request(1'b0, 8'h11);
      tick();
      bus.req_valid = 1'b0;
      check("miss_out_valid", 256'(bus.out_valid),     256'(1));
      check("miss_out_skip",  256'(bus.out_skip),      256'(1));
      check("miss_out_last",  256'(bus.out_last),      256'(1));
      check("miss_out_tag",   256'(bus.out_tag),       256'(8'h11));
      check("miss_out_ray",   256'(bus.out_ray),       256'(0));
      check("miss_light_idx", 256'(bus.out_light_idx), 256'(0));
      check("miss_gen_start", 256'(bus.gen_start),     256'(0));
      check("miss_req_ready", 256'(bus.req_ready),     256'(0));
      tick();
      check("miss_done_valid", 256'(bus.out_valid), 256'(0));
      check("miss_done_ready", 256'(bus.req_ready), 256'(1));

      // Hit, mask 1010, generator latency 3, first record backpressured 10 cycles
      bus.out_ready = 1'b0;
      cfg_light_en = 4'b1010;
      request(1'b1, 8'h22);
      hp_exp = '{x: 24'h001022, y: 24'h002000, z: 24'h003000};
      res_exp = '{hit: 1'b1, t_near: 24'h000100, t_far: 24'h000200};
      tick();                                   // T+1
      bus.req_valid = 1'b0;
      cfg_light_en = 4'b0000;                   // must not affect snapshot
      check("hit_gen_start1",  256'(bus.gen_start),       256'(1));
      check("hit_gen_light1",  256'(bus.gen_light),       256'(mk_light(1)));
      check("hit_gen_hp",      256'(bus.gen_hit_point),   256'(hp_exp));
      check("hit_gen_res",     256'(bus.gen_test_result), 256'(res_exp));
      check("hit_req_ready",   256'(bus.req_ready),       256'(0));
      tick();                                   // T+2
      check("hit_start_pulse", 256'(bus.gen_start), 256'(0));
      tick();                                   // T+3
      check("hit_no_early_out", 256'(bus.out_valid), 256'(0));
      tick();                                   // T+4
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(16);
      check("hit_no_out_t4", 256'(bus.out_valid), 256'(0));
      tick();                                   // T+5
      bus.gen_valid = 1'b0; bus.gen_shadow_ray = '0;
      check("hit1_out_valid", 256'(bus.out_valid),     256'(1));
      check("hit1_out_ray",   256'(bus.out_ray),       256'(mk_ray(16)));
      check("hit1_light_idx", 256'(bus.out_light_idx), 256'(1));
      check("hit1_out_last",  256'(bus.out_last),      256'(0));
      check("hit1_out_skip",  256'(bus.out_skip),      256'(0));
      check("hit1_out_tag",   256'(bus.out_tag),       256'(8'h22));
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_out_valid", 256'(bus.out_valid),     256'(1));
         check("bp_out_ray",   256'(bus.out_ray),       256'(mk_ray(16)));
         check("bp_light_idx", 256'(bus.out_light_idx), 256'(1));
         check("bp_req_ready", 256'(bus.req_ready),     256'(0));
         check("bp_gen_start", 256'(bus.gen_start),     256'(0));
      end
      bus.out_ready = 1'b1;
      tick();                                   // R+1
      check("hit_gen_start3", 256'(bus.gen_start), 256'(1));
      check("hit_gen_light3", 256'(bus.gen_light), 256'(mk_light(3)));
      check("hit_out_cleared", 256'(bus.out_valid), 256'(0));
      tick();                                   // WAIT, zero-latency reply
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(32);
      tick();
      bus.gen_valid = 1'b0;
      check("hit2_out_valid", 256'(bus.out_valid),     256'(1));
      check("hit2_out_ray",   256'(bus.out_ray),       256'(mk_ray(32)));
      check("hit2_light_idx", 256'(bus.out_light_idx), 256'(3));
      check("hit2_out_last",  256'(bus.out_last),      256'(1));
      tick();
      check("hit_done_valid", 256'(bus.out_valid), 256'(0));
      check("hit_done_ready", 256'(bus.req_ready), 256'(1));
      check("hit_done_start", 256'(bus.gen_start), 256'(0));

      // Hit with empty mask: single skip record, no generator start
      cfg_light_en = 4'b0000;
      request(1'b1, 8'h33);
      tick();
      bus.req_valid = 1'b0;
      check("m0_out_valid", 256'(bus.out_valid), 256'(1));
      check("m0_out_skip",  256'(bus.out_skip),  256'(1));
      check("m0_out_last",  256'(bus.out_last),  256'(1));
      check("m0_out_tag",   256'(bus.out_tag),   256'(8'h33));
      check("m0_gen_start", 256'(bus.gen_start), 256'(0));
      tick();
      check("m0_done_ready", 256'(bus.req_ready), 256'(1));
      check("m0_done_start", 256'(bus.gen_start), 256'(0));

      // Table write and accept on the same edge: new entry is used
      lnew = mk_light(7);
      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_light = lnew;
      cfg_light_en = 4'b0100;
      request(1'b1, 8'h44);
      tick();
      cfg_we = 1'b0; bus.req_valid = 1'b0;
      cfg_light_en = 4'b1111;                   // snapshot stays 0100
      check("wr_gen_start", 256'(bus.gen_start), 256'(1));
      check("wr_gen_light", 256'(bus.gen_light), 256'(lnew));
      tick();
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(48);
      tick();
      bus.gen_valid = 1'b0;
      check("wr_out_valid", 256'(bus.out_valid),     256'(1));
      check("wr_light_idx", 256'(bus.out_light_idx), 256'(2));
      check("wr_out_last",  256'(bus.out_last),      256'(1));
      check("wr_out_tag",   256'(bus.out_tag),       256'(8'h44));
      tick();

      // Reset mid-WAIT, then a late gen_valid
      cfg_light_en = 4'b0001;
      request(1'b1, 8'h55);
      tick();
      bus.req_valid = 1'b0;
      check("rw_gen_start", 256'(bus.gen_start), 256'(1));
      tick();                                   // WAIT
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(64);
      tick();
      bus.gen_valid = 1'b0;
      check("rw_out_valid", 256'(bus.out_valid),     256'(0));
      check("rw_req_ready", 256'(bus.req_ready),     256'(1));
      check("rw_out_tag",   256'(bus.out_tag),       256'(0));
      check("rw_gen_hp",    256'(bus.gen_hit_point), 256'(0));
      tick();
      check("rw_out_valid2", 256'(bus.out_valid), 256'(0));

      // Silent generator; the table was cleared by the reset above
      cfg_light_en = 4'b0001;
      request(1'b1, 8'h66);
      tick();                                   // gen_start cycle G
      bus.req_valid = 1'b0;
      check("to_gen_start", 256'(bus.gen_start), 256'(1));
      check("to_gen_light", 256'(bus.gen_light), 256'(0));
`ifdef SHADOW_SCHED_TIMEOUT_EN
      cnt = 0;
      while (!bus.out_valid && cnt < 30) begin
         tick();
         cnt++;
      end
      check("to_latency",   256'(cnt),               256'(9));
      check("to_out_skip",  256'(bus.out_skip),      256'(1));
      check("to_out_ray",   256'(bus.out_ray),       256'(0));
      check("to_light_idx", 256'(bus.out_light_idx), 256'(0));
      check("to_out_last",  256'(bus.out_last),      256'(1));
      check("to_err",       256'(timeout_err),       256'(1));
      tick();
      request(1'b0, 8'h77);
      tick();
      bus.req_valid = 1'b0;
      check("to_next_valid", 256'(bus.out_valid), 256'(1));
      check("to_err_sticky", 256'(timeout_err),   256'(1));
      tick();
      check("to_err_sticky2", 256'(timeout_err), 256'(1));
`else
      cnt = 0;
      repeat (20) begin
         tick();
         cnt++;
      end
      check("nto_out_valid", 256'(bus.out_valid), 256'(0));
      check("nto_req_ready", 256'(bus.req_ready), 256'(0));
      check("nto_err",       256'(timeout_err),   256'(0));
      bus.gen_valid = 1'b1; bus.gen_shadow_ray = mk_ray(80);
      tick();
      bus.gen_valid = 1'b0;
      check("nto_out_valid2", 256'(bus.out_valid), 256'(1));
      check("nto_out_skip",   256'(bus.out_skip),  256'(0));
      check("nto_out_ray",    256'(bus.out_ray),   256'(mk_ray(80)));
      check("nto_out_last",   256'(bus.out_last),  256'(1));
      tick();
      check("nto_done_ready", 256'(bus.req_ready), 256'(1));
      check("nto_err2",       256'(timeout_err),   256'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
